muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit for the EX stage, sitting beside the single-cycle ALU.

---
 rtl/muldiv_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit for the EX stage. Runs
//               MULT/MULTU/DIV/DIVU as WIDTH radix-2 steps on operand
//               magnitudes, then applies sign correction in a final FIX cycle.
//               Owns the architectural HI/LO pair and executes MTHI/MTLO.
//
// Ports       : i_clk    - clock, rising edge
//               i_rst    - synchronous active-high reset
//               i_valid  - request, sampled while o_ready=1
//               o_ready  - idle, can accept a request (~o_busy)
//               i_op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                          100 MTHI, 101 MTLO, 11x no-op
//               i_src1   - multiplicand / dividend / MTHI-MTLO data
//               i_src2   - multiplier / divisor
//               i_flush  - kill any in-flight operation, drop new request
//               o_busy   - multi-cycle operation in progress
//               o_done   - one-cycle pulse, HI/LO just written by MULT/DIV
//               o_hi     - HI (product high half / remainder)
//               o_lo     - LO (product low half / quotient)
//
// Config      : MULDIV_FASTPATH_EN - when defined, a divide by zero goes
//               straight from IDLE to FIX (o_done two cycles after accept).
//
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [2:0] c_op_mthi = 3'b100;
    localparam logic [2:0] c_op_mtlo = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Architectural registers
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    // Working registers for the iterative operation
    logic [WIDTH-1:0] r_acc_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] r_acc_lo;   // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] r_b;        // |src2|
    logic [WIDTH-1:0] r_src1;     // raw dividend, returned as HI on divide by zero
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;    // product / quotient sign
    logic             r_neg_r;    // remainder sign (dividend sign)
    logic             r_div_zero;

    logic             w_accept;
    logic             w_is_muldiv;
    logic             w_is_signed;
    logic             w_src2_zero;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_rem;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // ------------------------------------------------------------------------
    // Request decode and operand magnitudes
    // ------------------------------------------------------------------------
    assign o_busy      = (r_state != ST_IDLE);
    assign o_ready     = ~o_busy;
    assign o_done      = r_done;
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;

    assign w_accept    = i_valid & o_ready & ~i_flush;
    assign w_is_muldiv = ~i_op[2];
    assign w_is_signed = ~i_op[0];
    assign w_src2_zero = (i_src2 == '0);
    assign w_neg1      = w_is_signed & i_src1[WIDTH-1];
    assign w_neg2      = w_is_signed & i_src2[WIDTH-1];
    assign w_mag1      = w_neg1 ? (-i_src1) : i_src1;
    assign w_mag2      = w_neg2 ? (-i_src2) : i_src2;

    // ------------------------------------------------------------------------
    // One radix-2 step. Multiply: shift-add, with the product high half
    // growing in r_acc_hi while the multiplier drains out of r_acc_lo.
    // Divide: restoring division, dividend bits shift from r_acc_lo into the
    // partial remainder and quotient bits shift in behind them.
    // ------------------------------------------------------------------------
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    // When the subtract succeeds the true remainder is below r_b, so the
    // modulo-2^WIDTH difference is exact.
    assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_b;

    always_comb begin
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        if (r_is_div) begin
            w_step_hi = w_div_ok ? w_div_rem : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_div_ok};
        end else begin
            {w_step_hi, w_step_lo} = {w_mul_sum, r_acc_lo[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Sign correction / final result selection
    // ------------------------------------------------------------------------
    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_prod_s = r_neg_q ? (-w_prod) : w_prod;

    always_comb begin
        w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_s[WIDTH-1:0];
        if (r_div_zero) begin
            w_fix_hi = r_src1;
            w_fix_lo = '1;
        end else if (r_is_div) begin
            // MIN / -1 yields magnitude quotient 2^(WIDTH-1) with a positive
            // sign, which already reads back as MIN without any special case.
            w_fix_hi = r_neg_r ? (-r_acc_hi) : r_acc_hi;
            w_fix_lo = r_neg_q ? (-r_acc_lo) : r_acc_lo;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_muldiv) begin
`ifdef MULDIV_FASTPATH_EN
                    w_state_next = (i_op[1] && w_src2_zero) ? ST_FIX : ST_CALC;
`else
                    w_state_next = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_b        <= '0;
            r_src1     <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_muldiv) begin
                            r_is_div   <= i_op[1];
                            r_neg_q    <= w_neg1 ^ w_neg2;
                            r_neg_r    <= w_neg1;
                            r_div_zero <= i_op[1] & w_src2_zero;
                            r_src1     <= i_src1;
                            r_b        <= w_mag2;
                            r_acc_hi   <= '0;
                            r_acc_lo   <= w_mag1;
                            r_cnt      <= CNT_W'(WIDTH - 1);
                        end else if (i_op == c_op_mthi) begin
                            r_hi <= i_src1;
                        end else if (i_op == c_op_mtlo) begin
                            r_lo <= i_src1;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [2:0] c_mult  = 3'b000;
    localparam logic [2:0] c_multu = 3'b001;
    localparam logic [2:0] c_div   = 3'b010;
    localparam logic [2:0] c_divu  = 3'b011;
    localparam logic [2:0] c_mthi  = 3'b100;
    localparam logic [2:0] c_mtlo  = 3'b101;

`ifdef MULDIV_FASTPATH_EN
    localparam int c_lat_dz = 2;
`else
    localparam int c_lat_dz = 34;
`endif

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic seen;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .o_ready (ready),
        .i_op    (op),
        .i_src1  (src1),
        .i_src2  (src2),
        .i_flush (flush),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for o_done, counting cycles since the accept cycle; a timeout
    // leaves lat at 100, which no latency check accepts.
    task automatic wait_done(inout int l);
        while (!done && l < 100) begin
            tick();
            l++;
        end
    endtask

    // Present one request in the current cycle; operands are scrambled after
    // the accept edge so the DUT must have latched them.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int l);
        valid = 1'b1; op = o; src1 = a; src2 = b;
        tick();
        valid = 1'b0; src1 = 32'hA5A5_A5A5; src2 = 32'h5A5A_5A5A;
        l = 1;
        wait_done(l);
    endtask

    task automatic pulse(input logic [2:0] o, input logic [31:0] a);
        valid = 1'b1; op = o; src1 = a; src2 = 32'h0;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; op = 3'b000; src1 = '0; src2 = '0;
        repeat (2) tick();
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_ready", {63'h0, ready}, 64'h1);
        rst = 1'b0;
        tick();

        // MULT -1 * 2, with busy/ready checked in the first CALC cycle
        valid = 1'b1; op = c_mult; src1 = 32'hFFFF_FFFF; src2 = 32'h2;
        tick();
        valid = 1'b0; src1 = 32'h0; src2 = 32'h0;
        check("mult_busy_n1", {63'h0, busy}, 64'h1);
        check("mult_ready_n1", {63'h0, ready}, 64'h0);
        lat = 1;
        wait_done(lat);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_hi", {32'h0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'h0, lo}, 64'hFFFF_FFFE);

        // Each following op is issued in the o_done cycle of the previous one
        run_op(c_multu, 32'hFFFF_FFFF, 32'h2, lat);
        check("multu_lat", 64'(lat), 64'd34);
        check("multu_hi", {32'h0, hi}, 64'h1);
        check("multu_lo", {32'h0, lo}, 64'hFFFF_FFFE);

        run_op(c_div, 32'hFFFF_FFF9, 32'h2, lat);
        check("div_m7_2_lat", 64'(lat), 64'd34);
        check("div_m7_2_lo", {32'h0, lo}, 64'hFFFF_FFFD);
        check("div_m7_2_hi", {32'h0, hi}, 64'hFFFF_FFFF);

        run_op(c_divu, 32'd100, 32'd7, lat);
        check("divu_100_7_lo", {32'h0, lo}, 64'd14);
        check("divu_100_7_hi", {32'h0, hi}, 64'd2);

        run_op(c_div, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_min_lo", {32'h0, lo}, 64'h8000_0000);
        check("div_min_hi", {32'h0, hi}, 64'h0);

        run_op(c_mult, 32'hFFFF_FFFD, 32'h0000_0007, lat);
        check("mult_m3_7_hi", {32'h0, hi}, 64'hFFFF_FFFF);
        check("mult_m3_7_lo", {32'h0, lo}, 64'hFFFF_FFEB);

        run_op(c_divu, 32'd5, 32'd0, lat);
        check("divu_dz_lat", 64'(lat), 64'(c_lat_dz));
        check("divu_dz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
        check("divu_dz_hi", {32'h0, hi}, 64'd5);

        run_op(c_div, 32'hFFFF_FFFB, 32'd0, lat);
        check("div_dz_lat", 64'(lat), 64'(c_lat_dz));
        check("div_dz_lo", {32'h0, lo}, 64'hFFFF_FFFF);
        check("div_dz_hi", {32'h0, hi}, 64'hFFFF_FFFB);
        tick();
        check("done_pulse", {63'h0, done}, 64'h0);

        // MTLO / MTHI write at the accept edge, no busy, no done
        pulse(c_mtlo, 32'h0000_1234);
        check("mtlo_lo", {32'h0, lo}, 64'h1234);
        check("mtlo_busy", {63'h0, busy}, 64'h0);
        check("mtlo_done", {63'h0, done}, 64'h0);
        pulse(c_mthi, 32'h0000_ABCD);
        check("mthi_hi", {32'h0, hi}, 64'hABCD);

        // MULT 3*4 flushed in cycle N+10
        valid = 1'b1; op = c_mult; src1 = 32'd3; src2 = 32'd4;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", {63'h0, ready}, 64'h1);
        check("flush_busy", {63'h0, busy}, 64'h0);
        seen = done;
        repeat (40) begin
            tick();
            seen = seen | done;
        end
        check("flush_no_done", {63'h0, seen}, 64'h0);
        check("flush_lo", {32'h0, lo}, 64'h1234);
        check("flush_hi", {32'h0, hi}, 64'hABCD);

        // Flush in IDLE drops an MTHI request
        flush = 1'b1;
        pulse(c_mthi, 32'hDEAD_BEEF);
        flush = 1'b0;
        check("idle_flush_hi", {32'h0, hi}, 64'hABCD);

        // 11x is a no-op
        pulse(3'b110, 32'h7777_7777);
        check("nop_busy", {63'h0, busy}, 64'h0);
        check("nop_hi", {32'h0, hi}, 64'hABCD);
        check("nop_lo", {32'h0, lo}, 64'h1234);

        // Request held while busy is ignored
        valid = 1'b1; op = c_multu; src1 = 32'd2; src2 = 32'd3;
        tick();
        op = c_mtlo; src1 = 32'h55;
        tick();
        valid = 1'b0;
        check("busy_ignore_lo", {32'h0, lo}, 64'h1234);
        lat = 2;
        wait_done(lat);
        check("busy_op_lat", 64'(lat), 64'd34);
        check("busy_op_lo", {32'h0, lo}, 64'd6);
        check("busy_op_hi", {32'h0, hi}, 64'd0);

        // Reset in the middle of a divide
        pulse(c_mthi, 32'h0000_0077);
        valid = 1'b1; op = c_div; src1 = 32'd100; src2 = 32'd7;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst_hi", {32'h0, hi}, 64'h0);
        check("midrst_lo", {32'h0, lo}, 64'h0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
